// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
// Holds the FSM state enum, the latched request record, the default word-index
// width, the legal data window and the byte-enable legality helper.
package dmem_pkg;

    localparam int DMEM_WORD_ADDR_BITS = 15;

    // Legal byte-address window, inclusive on both ends; covers the default
    // 2**15-word storage exactly.
    localparam logic [31:0] DMEM_DATA_BEGIN = 32'h0000_0000;
    localparam logic [31:0] DMEM_DATA_END   = 32'h0001_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [3:0]  byteena;
        logic [31:0] wdata;
    } req_t;

    // Naturally aligned byte, halfword and word lane patterns, plus the empty mask.
    function automatic logic byteena_legal(input logic [3:0] be);
        logic ok;
        case (be)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between an initiator (master) and the data memory
// responder (slave).
interface data_memory_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [3:0]  req_byteena;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_address, req_byteena, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_address, req_byteena, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/dmem_byte_ram.sv
// Synchronous single-port RAM of 32-bit words with per-byte write enables.
// q is registered: it shows the word at 'address' as it was before any write
// on the same edge. Contents are never reset.
module dmem_byte_ram #(
    parameter int ADDR_BITS = 15
) (
    input  logic                 clock,
    input  logic [ADDR_BITS-1:0] address,
    input  logic [3:0]           byteena,
    input  logic [31:0]          data,
    input  logic                 wren,
    output logic [31:0]          q
);

    logic [31:0] mem [2**ADDR_BITS];

    // Lane-masked write and registered read of the addressed word.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (wren && byteena[i]) begin
                mem[address][8*i +: 8] <= data[8*i +: 8];
            end
        end
        q <= mem[address];
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data memory responder: accepts one load/store at a time, waits WAIT_STATES
// cycles, performs the access on dmem_byte_ram and holds the response until
// the initiator takes it.
//
// Optional build macro: DMEM_MISALIGN_ERROR_EN -- when defined, byte-enable
// patterns that are not an aligned byte/halfword/word (or empty) are rejected
// with resp_error and no write. Undefined: any mask is a plain lane mask.
//
// With WAIT_STATES == 0 the access happens on the acceptance edge itself, so the
// RAM is driven straight from the bus while IDLE; otherwise it is driven from
// the latched request.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int WAIT_STATES    = 1,
    parameter int WORD_ADDR_BITS = DMEM_WORD_ADDR_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    data_memory_responder_if.slave bus
);

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    req_t        req_q;
    req_t        req_live;
    req_t        acc_req;
    logic        accept;
    logic        access_fire;
    logic        acc_err;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic        rsp_valid;
    logic        rsp_error;
    logic        load_ok;

    // Out-of-window addresses always fail; lane patterns only when the macro is set.
    function automatic logic req_rejected(input req_t r);
        logic err;
        err = (r.address - DMEM_DATA_BEGIN) > (DMEM_DATA_END - DMEM_DATA_BEGIN);
`ifdef DMEM_MISALIGN_ERROR_EN
        if (!byteena_legal(r.byteena)) begin
            err = 1'b1;
        end
`endif
        return err;
    endfunction

    assign req_live = '{write:   bus.req_write,
                        address: bus.req_address,
                        byteena: bus.req_byteena,
                        wdata:   bus.req_wdata};

    assign accept      = bus.req_valid && (state == IDLE);
    assign acc_req     = (state == IDLE) ? req_live : req_q;
    assign acc_err     = req_rejected(acc_req);
    assign access_fire = (NO_WAIT && accept) || ((state == WAIT) && (cnt == 4'd0));
    assign ram_wren    = access_fire && acc_req.write && !acc_err;

    // State and wait counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and wait-counter decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (NO_WAIT) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch every request field on acceptance; the bus is ignored afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= req_live;
        end
    end

    // Response flags: set on the access edge, cleared on the response handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            load_ok   <= 1'b0;
        end else if (access_fire) begin
            rsp_valid <= 1'b1;
            rsp_error <= acc_err;
            load_ok   <= !acc_req.write && !acc_err;
        end else if ((state == RESP) && bus.resp_ready) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            load_ok   <= 1'b0;
        end
    end

    dmem_byte_ram #(
        .ADDR_BITS (WORD_ADDR_BITS)
    ) u_ram (
        .clock   (clock),
        .address (acc_req.address[WORD_ADDR_BITS+1:2]),
        .byteena (acc_req.byteena),
        .data    (acc_req.wdata),
        .wren    (ram_wren),
        .q       (ram_q)
    );

    // RAM address and data are held during RESP, so q stays stable until the handshake.
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = rsp_valid;
    assign bus.resp_error = rsp_error;
    assign bus.resp_rdata = load_ok ? ram_q : 32'h0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder (WAIT_STATES = 1).
// Expected values come from a word-array reference model applying the
// load/store/window/lane rules directly.
module tb_data_memory_responder;

    localparam int          WS         = 1;
    localparam int          AW         = 15;
    localparam logic [31:0] DATA_BEGIN = 32'h0000_0000;
    localparam logic [31:0] DATA_END   = 32'h0001_FFFF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] mdl [int];

    data_memory_responder_if bus();

    data_memory_responder #(
        .WAIT_STATES    (WS),
        .WORD_ADDR_BITS (AW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic bit aligned_pattern(input logic [3:0] be);
        return be inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                          4'b0011, 4'b1100, 4'b1111};
    endfunction

    // Reference model: returns expected rdata/error and updates the model memory.
    task automatic model_op(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd, output logic [31:0] er, output logic ee);
        int          idx;
        logic [31:0] w;
        bit          reject;
        idx    = int'((addr / 4) % (1 << AW));
        reject = (longint'(addr) < longint'(DATA_BEGIN)) || (longint'(addr) > longint'(DATA_END));
`ifdef DMEM_MISALIGN_ERROR_EN
        reject = reject || !aligned_pattern(be);
`endif
        w  = mdl.exists(idx) ? mdl[idx] : 32'h0;
        er = 32'h0;
        ee = reject;
        if (!reject) begin
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
                end
                mdl[idx] = w;
            end else begin
                er = w;
            end
        end
    endtask

    // Drive one request, scramble the bus after acceptance, wait for the response,
    // optionally stall it, then complete the handshake. lat = cycle (1-based after
    // the acceptance edge) in which resp_valid was first seen.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat);
        int g;
        @(negedge clock);
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_address = addr;
        bus.req_byteena = be;
        bus.req_wdata   = wd;
        g = 0;
        while (!bus.req_ready && g < 50) begin
            @(negedge clock);
            g++;
        end
        if (!bus.req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, want 1", bus.req_ready, g);
        end
        @(posedge clock);
        #1;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'($urandom);
        bus.req_address = $urandom;
        bus.req_byteena = 4'($urandom);
        bus.req_wdata   = $urandom;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_timeout: resp_valid=%0b after 40 cycles, want 1", bus.resp_valid);
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_error;
        repeat (hold) @(negedge clock);
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_error} !== 3'b100 || bus.resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: ready/valid/error=%b rdata=%h, want 100 rdata=00000000",
                     {bus.req_ready, bus.resp_valid, bus.resp_error}, bus.resp_rdata);
        end
    endtask

    task automatic check_op(input string name, input logic wr, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd, input int hold);
        logic [31:0] er, gr;
        logic        ee, ge;
        int          lat;
        model_op(wr, addr, be, wd, er, ee);
        do_req(wr, addr, be, wd, hold, gr, ge, lat);
        n_cmp++;
        if (gr !== er) begin
            n_bad++;
            $display("FAIL %s rdata: got %h want %h (addr %h be %b wr %0b)", name, gr, er, addr, be, wr);
        end
        n_cmp++;
        if (ge !== ee) begin
            n_bad++;
            $display("FAIL %s error: got %0b want %0b (addr %h be %b wr %0b)", name, ge, ee, addr, be, wr);
        end
        n_cmp++;
        if (lat != WS + 1) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, WS + 1);
        end
    endtask

    task automatic test_basic();
        check_op("store_word", 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 0);
        check_op("load_word",  1'b0, 32'h0000_0010, 4'b1111, 32'h0, 0);
        check_op("store_lane1", 1'b1, 32'h0000_0010, 4'b0010, 32'h0000_AA00, 1);
        check_op("load_merged", 1'b0, 32'h0000_0010, 4'b1111, 32'h0, 0);
        n_cmp++;
        if (mdl[4] !== 32'hDEAD_AAEF) begin
            n_bad++;
            $display("FAIL model_merge: got %h want DEADAAEF", mdl[4]);
        end
    endtask

    task automatic test_bounds();
        check_op("word0_init",   1'b1, 32'h0000_0000, 4'b1111, 32'h0BAD_F00D, 0);
        check_op("top_store",    1'b1, DATA_END - 32'd3, 4'b1111, 32'hCAFE_F00D, 0);
        check_op("top_load",     1'b0, DATA_END - 32'd3, 4'b1111, 32'h0, 0);
        check_op("over_load",    1'b0, DATA_END + 32'd4, 4'b1111, 32'h0, 0);
        check_op("over_store",   1'b1, DATA_END + 32'd1, 4'b1111, 32'hFFFF_FFFF, 0);
        check_op("word0_intact", 1'b0, 32'h0000_0000, 4'b1111, 32'h0, 0);
    endtask

    task automatic test_zero_byteena();
        check_op("store_be0", 1'b1, 32'h0000_0010, 4'b0000, 32'h5555_5555, 0);
        check_op("load_be0",  1'b0, 32'h0000_0010, 4'b1111, 32'h0, 0);
    endtask

    task automatic test_misalign();
        check_op("store_be0110", 1'b1, 32'h0000_0010, 4'b0110, 32'h1122_3344, 0);
        check_op("load_be0110",  1'b0, 32'h0000_0010, 4'b1111, 32'h0, 0);
    endtask

    task automatic test_hold();
        logic [31:0] er;
        logic        ee;
        int          g;
        model_op(1'b0, 32'h0000_0010, 4'b1111, 32'h0, er, ee);
        @(negedge clock);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b0;
        bus.req_address = 32'h0000_0010;
        bus.req_byteena = 4'b1111;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (!bus.resp_valid && g < 40);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({bus.resp_valid, bus.req_ready, bus.resp_error} !== {2'b10, ee} || bus.resp_rdata !== er) begin
                n_bad++;
                $display("FAIL hold_stable[%0d]: valid/ready/err=%b rdata=%h, want %b rdata=%h",
                         c, {bus.resp_valid, bus.req_ready, bus.resp_error}, bus.resp_rdata, {2'b10, ee}, er);
            end
            @(negedge clock);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL hold_release: ready/valid=%b want 10", {bus.req_ready, bus.resp_valid});
        end
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        @(negedge clock);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b1;
        bus.req_address = 32'h0000_0010;
        bus.req_byteena = 4'b1111;
        bus.req_wdata   = 32'h1234_5678;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_reset_ready: req_ready=%0b want 1", bus.req_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (bus.resp_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL wait_reset_noresp: resp_valid seen=1 want 0");
        end
        check_op("wait_reset_old", 1'b0, 32'h0000_0010, 4'b1111, 32'h0, 0);
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] a;
        pool[0] = DATA_END - 32'd3;
        pool[1] = 32'h0000_0000;
        for (int i = 2; i < 8; i++) pool[i] = {15'h0, 15'($urandom), 2'b00};
        for (int i = 0; i < 8; i++) check_op("rnd_init", 1'b1, pool[i], 4'b1111, $urandom, 0);
        for (int n = 0; n < 60; n++) begin
            a = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = a + 32'h0002_0000;
            check_op("rnd_op", 1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        int          acc_at [$];
        logic [31:0] er;
        logic        ee;
        int          g;
        model_op(1'b0, 32'h0000_0010, 4'b1111, 32'h0, er, ee);
        @(negedge clock);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b0;
        bus.req_address = 32'h0000_0010;
        bus.req_byteena = 4'b1111;
        bus.resp_ready  = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus.req_ready) acc_at.push_back(c);
            if (bus.resp_valid) begin
                n_cmp++;
                if (bus.resp_rdata !== er || bus.resp_error !== ee) begin
                    n_bad++;
                    $display("FAIL b2b_data: rdata=%h err=%0b want %h %0b", bus.resp_rdata, bus.resp_error, er, ee);
                end
            end
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        g = 0;
        while (!bus.req_ready && g < 20) begin
            @(negedge clock);
            g++;
        end
        bus.resp_ready = 1'b0;
        n_cmp++;
        if (acc_at.size() < 4) begin
            n_bad++;
            $display("FAIL b2b_count: accepts=%0d want >=4", acc_at.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (acc_at[i] - acc_at[i-1] != WS + 2) begin
                    n_bad++;
                    $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc_at[i] - acc_at[i-1], WS + 2);
                end
            end
        end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_address = 32'h0;
        bus.req_byteena = 4'h0;
        bus.req_wdata   = 32'h0;
        bus.resp_ready  = 1'b0;
        test_reset();
        test_basic();
        test_bounds();
        test_zero_byteena();
        test_misalign();
        test_hold();
        test_reset_in_wait();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, meaning idle cycles inserted between request acceptance and the memory access (range 0..15).
REQ-002 The block SHALL have parameter WORD_ADDR_BITS, default 15, meaning the word-index width; storage depth is 2**WORD_ADDR_BITS 32-bit words.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_address  input  32  byte address; word index = req_address[WORD_ADDR_BITS+1:2].
REQ-009 req_byteena  input  4  byte-lane write mask; lane i = bits [8i+7:8i].
REQ-010 req_wdata  input  32  store data, lane-aligned.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  full loaded word, unshifted; 0 for stores and errors.
REQ-014 resp_error  output  1  request rejected; no memory side effect.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance is req_valid & req_ready at a rising edge; all request fields SHALL be latched then, and inputs are ignored afterwards.
REQ-018 On acceptance, IDLE SHALL go to WAIT with the counter loaded to WAIT_STATES-1 if WAIT_STATES>0; if WAIT_STATES==0 it SHALL go directly to RESP.
REQ-019 WAIT SHALL decrement the counter each cycle and, on the cycle it reads 0, perform the access and go to RESP.
REQ-020 Latency: resp_valid SHALL rise exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-021 The access SHALL write only the lanes set in latched byteena; a load SHALL register the whole addressed word into resp_rdata.
REQ-022 An address outside DATA_BEGIN..DATA_END inclusive (config constants) SHALL set resp_error=1 and resp_rdata=0, with no write.
REQ-023 A store with byteena=0000 SHALL be a no-op with a normal response, resp_error=0.
REQ-024 In RESP, resp_valid, resp_rdata and resp_error SHALL hold stable until resp_ready=1.
REQ-025 On the handshake edge RESP SHALL go to IDLE; req_ready SHALL be 0 during that cycle, so no same-cycle re-accept occurs.
REQ-026 The minimum request-to-request spacing SHALL be WAIT_STATES+2 cycles.

Reset
REQ-027 Reset SHALL force IDLE, counter=0, resp_valid=0, resp_error=0 and resp_rdata=0; req_ready SHALL be 1 immediately after reset deasserts.
REQ-028 A reset during WAIT SHALL abandon the request with no write; storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro DMEM_MISALIGN_ERROR_EN, when defined, SHALL make byteena patterns other than 0001/0010/0100/1000/0011/1100/1111 and 0000 return resp_error=1 with no write.
REQ-030 When DMEM_MISALIGN_ERROR_EN is undefined, any byteena pattern SHALL be honoured as a plain lane mask with no error.

Structure
REQ-031 Shared package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), a request struct (write, address, byteena, wdata) and the default for WORD_ADDR_BITS.
REQ-032 Storage SHALL be the sub-module dmem_byte_ram: synchronous byte-enabled RAM with ports clock, address, byteena, data, wren and q.

Verification
REQ-033 Store 0xDEADBEEF to 0x00000010 with byteena 1111, then load it -> load returns 0xDEADBEEF; resp_valid rises 2 cycles after each accept (WAIT_STATES=1).
REQ-034 After REQ-033, store 0x0000AA00 with byteena 0010, then load -> 0xDEADAAEF.
REQ-035 Load at address DATA_END+4 -> resp_error=1, resp_rdata=0; a load at DATA_END-3 succeeds.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; resp_ready=1 -> IDLE next cycle.
REQ-037 Assert reset in WAIT during a store of 0x12345678 -> later load returns the old word; no response is ever issued.
REQ-038 With DMEM_MISALIGN_ERROR_EN defined, store with byteena 0110 -> resp_error=1 and memory unchanged; with it undefined -> lanes 1 and 2 are written.
